// File: rtl/rip_sat_counter_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rip_sat_counter_predictor_pkg
// Brief    : Shared branch-predictor types, default parameters and the
//            saturating-counter step function.
// Revision : 1.0
// ============================================================================
package rip_sat_counter_predictor_pkg;

  typedef enum logic {
    BP_BIMODAL = 1'b0,
    BP_GSHARE  = 1'b1
  } bp_mode_e;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } bp_state_e;

  localparam int unsigned BP_CTR_WIDTH_DEF   = 2;
  localparam int unsigned BP_INDEX_WIDTH_DEF = 10;
  localparam int unsigned BP_HISTORY_LEN_DEF = 10;
  localparam int unsigned BP_PC_LSB_DEF      = 2;
  localparam bp_mode_e    BP_MODE_DEF        = BP_GSHARE;
  localparam int unsigned BP_CTR_WIDTH_MAX   = 4;

  typedef logic [BP_CTR_WIDTH_DEF-1:0] bp_ctr_t;
  typedef logic [BP_CTR_WIDTH_MAX-1:0] bp_ctr_max_t;

  // Saturating step for a counter of the given width, carried in the widest container.
  function automatic bp_ctr_max_t bp_ctr_next(bp_ctr_max_t ctr, logic taken, int unsigned width);
    bp_ctr_max_t sat_max;
    sat_max = bp_ctr_max_t'((32'd1 << width) - 32'd1);
    if (taken) begin
      return (ctr == sat_max) ? ctr : ctr + bp_ctr_max_t'(1);
    end
    return (ctr == '0) ? ctr : ctr - bp_ctr_max_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rip_bp_counter_table.sv
`default_nettype none
// ============================================================================
// Module   : rip_bp_counter_table
// Brief    : Saturating-counter table: one read port with update bypass, one
//            write port shared by the init sweep and the resolved updates.
// Revision : 1.0
// ============================================================================
module rip_bp_counter_table
  import rip_sat_counter_predictor_pkg::*;
#(
  parameter int unsigned CTR_WIDTH   = BP_CTR_WIDTH_DEF,
  parameter int unsigned INDEX_WIDTH = BP_INDEX_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   init_we_i,
  input  logic [INDEX_WIDTH-1:0] init_idx_i,
  input  logic [CTR_WIDTH-1:0]   init_val_i,
  input  logic                   upd_we_i,
  input  logic [INDEX_WIDTH-1:0] upd_idx_i,
  input  logic                   upd_taken_i,
  input  logic [INDEX_WIDTH-1:0] rd_idx_i,
  output logic [CTR_WIDTH-1:0]   rd_ctr_o
);

  localparam int unsigned C_DEPTH = 1 << INDEX_WIDTH;

  logic [CTR_WIDTH-1:0] mem_q [C_DEPTH];
  logic [CTR_WIDTH-1:0] w_upd_ctr;
  logic                 w_bypass;

  always_comb begin
    w_upd_ctr = CTR_WIDTH'(bp_ctr_next(bp_ctr_max_t'(mem_q[upd_idx_i]), upd_taken_i, CTR_WIDTH));
    w_bypass  = upd_we_i && !init_we_i && (upd_idx_i == rd_idx_i);
    rd_ctr_o  = w_bypass ? w_upd_ctr : mem_q[rd_idx_i];
  end

  // Contents are defined by the init sweep, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (init_we_i) begin
      mem_q[init_idx_i] <= init_val_i;
    end else if (upd_we_i) begin
      mem_q[upd_idx_i] <= w_upd_ctr;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rip_sat_counter_predictor.sv
`default_nettype none
// ============================================================================
// Module   : rip_sat_counter_predictor
// Brief    : Bimodal / gshare saturating-counter direction predictor with a
//            power-up init sweep and speculative global history.
// Revision : 1.0
// ============================================================================
module rip_sat_counter_predictor
  import rip_sat_counter_predictor_pkg::*;
#(
  parameter int unsigned CTR_WIDTH   = BP_CTR_WIDTH_DEF,
  parameter int unsigned INDEX_WIDTH = BP_INDEX_WIDTH_DEF,
  parameter int unsigned HISTORY_LEN = BP_HISTORY_LEN_DEF,
  parameter int unsigned MODE        = int'(BP_MODE_DEF),
  parameter int unsigned PC_LSB      = BP_PC_LSB_DEF,
  parameter int unsigned INIT_CTR    = (1 << (CTR_WIDTH - 1)) - 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   pred_valid_i,
  input  logic [31:0]            pred_pc_i,
  output logic                   pred_ready_o,
  output logic                   pred_valid_o,
  output logic                   pred_taken_o,
  output logic [INDEX_WIDTH-1:0] pred_index_o,
  output logic [HISTORY_LEN-1:0] pred_ghr_o,
  input  logic                   upd_valid_i,
  input  logic [INDEX_WIDTH-1:0] upd_index_i,
  input  logic                   upd_taken_i,
  input  logic                   upd_mispredict_i,
  input  logic [HISTORY_LEN-1:0] upd_ghr_i,
  output logic                   init_busy_o
);

  bp_state_e              state_q;
  logic [INDEX_WIDTH-1:0] sweep_q;
  logic [HISTORY_LEN-1:0] ghr_q, ghr_d;
  logic                   pred_valid_q, pred_taken_q;
  logic [INDEX_WIDTH-1:0] pred_index_q;
  logic [HISTORY_LEN-1:0] pred_ghr_q;

  logic                   w_ready_state;
  logic                   w_upd_we;
  logic                   w_recover;
  logic                   w_accept;
  logic [INDEX_WIDTH-1:0] w_pc_idx;
  logic [INDEX_WIDTH-1:0] w_index;
  logic [CTR_WIDTH-1:0]   w_rd_ctr;
  logic                   w_pred_taken;
  logic [HISTORY_LEN-1:0] w_ghr_spec;
  logic [HISTORY_LEN-1:0] w_ghr_rec;
  logic                   w_unused_bits;

  assign w_ready_state = (state_q == ST_READY);
  assign w_upd_we      = w_ready_state && upd_valid_i;
  assign w_recover     = w_upd_we && upd_mispredict_i;
  assign pred_ready_o  = w_ready_state && !(upd_valid_i && upd_mispredict_i);
  assign w_accept      = pred_valid_i && pred_ready_o;
  assign w_pc_idx      = pred_pc_i[PC_LSB +: INDEX_WIDTH];
  assign w_pred_taken  = w_rd_ctr[CTR_WIDTH-1];
  assign w_unused_bits = ^{pred_pc_i, upd_ghr_i, w_rd_ctr};

  generate
    if (MODE == int'(BP_GSHARE)) begin : g_gshare
      assign w_index = w_pc_idx ^ INDEX_WIDTH'(ghr_q);
    end else begin : g_bimodal
      assign w_index = w_pc_idx;
    end
  endgenerate

  generate
    if (HISTORY_LEN == 1) begin : g_ghr_len1
      assign w_ghr_spec = w_pred_taken;
      assign w_ghr_rec  = upd_taken_i;
    end else begin : g_ghr_shift
      assign w_ghr_spec = {ghr_q[HISTORY_LEN-2:0], w_pred_taken};
      assign w_ghr_rec  = {upd_ghr_i[HISTORY_LEN-2:0], upd_taken_i};
    end
  endgenerate

  // Misprediction recovery overrides the speculative shift of the same cycle.
  always_comb begin
    ghr_d = ghr_q;
    if (w_recover) begin
      ghr_d = w_ghr_rec;
    end else if (w_accept) begin
      ghr_d = w_ghr_spec;
    end
  end

  rip_bp_counter_table #(
    .CTR_WIDTH   (CTR_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_table (
    .clk         (clk),
    .init_we_i   (!w_ready_state),
    .init_idx_i  (sweep_q),
    .init_val_i  (CTR_WIDTH'(INIT_CTR)),
    .upd_we_i    (w_upd_we),
    .upd_idx_i   (upd_index_i),
    .upd_taken_i (upd_taken_i),
    .rd_idx_i    (w_index),
    .rd_ctr_o    (w_rd_ctr)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_index_q <= '0;
      pred_ghr_q   <= '0;
    end else begin
      ghr_q        <= ghr_d;
      pred_valid_q <= w_accept;
      if (w_accept) begin
        pred_taken_q <= w_pred_taken;
        pred_index_q <= w_index;
        pred_ghr_q   <= ghr_q;
      end
      case (state_q)
        ST_INIT: begin
          sweep_q <= sweep_q + INDEX_WIDTH'(1);
          if (sweep_q == {INDEX_WIDTH{1'b1}}) begin
            state_q <= ST_READY;
          end
        end
        default: state_q <= ST_READY;
      endcase
    end
  end

  assign pred_valid_o = pred_valid_q;
  assign pred_taken_o = pred_taken_q;
  assign pred_index_o = pred_index_q;
  assign pred_ghr_o   = pred_ghr_q;
  assign init_busy_o  = (state_q == ST_INIT);

endmodule
`default_nettype wire

// File: tb/tb_rip_sat_counter_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_rip_sat_counter_predictor
// Brief    : Scoreboard bench for the gshare predictor at default parameters.
// Revision : 1.0
// ============================================================================
module tb_rip_sat_counter_predictor;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pred_valid_i = 1'b0;
  logic [31:0] pred_pc_i = '0;
  logic        pred_ready_o, pred_valid_o, pred_taken_o, init_busy_o;
  logic [9:0]  pred_index_o, pred_ghr_o;
  logic        upd_valid_i = 1'b0;
  logic [9:0]  upd_index_i = '0;
  logic        upd_taken_i = 1'b0;
  logic        upd_mispredict_i = 1'b0;
  logic [9:0]  upd_ghr_i = '0;

  always #5 clk = ~clk;

  rip_sat_counter_predictor dut (
    .clk              (clk),
    .rstn             (rstn),
    .pred_valid_i     (pred_valid_i),
    .pred_pc_i        (pred_pc_i),
    .pred_ready_o     (pred_ready_o),
    .pred_valid_o     (pred_valid_o),
    .pred_taken_o     (pred_taken_o),
    .pred_index_o     (pred_index_o),
    .pred_ghr_o       (pred_ghr_o),
    .upd_valid_i      (upd_valid_i),
    .upd_index_i      (upd_index_i),
    .upd_taken_i      (upd_taken_i),
    .upd_mispredict_i (upd_mispredict_i),
    .upd_ghr_i        (upd_ghr_i),
    .init_busy_o      (init_busy_o)
  );

  typedef struct packed {
    logic       taken;
    logic [9:0] idx;
    logic [9:0] ghr;
  } pred_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] m_ctr [DEPTH];
  logic [9:0] m_ghr = '0;
  bit         m_ready = 1'b0;
  pred_t      sb_q [$];

  function automatic logic [1:0] sat(logic [1:0] c, logic t);
    if (t) return (c == 2'b11) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [31:0] pc_for(logic [9:0] idx);
    return {20'd0, idx ^ m_ghr, 2'b00};
  endfunction

  task automatic model_reset();
    m_ghr   = '0;
    m_ready = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_init_done();
    for (int i = 0; i < DEPTH; i++) m_ctr[i] = 2'b01;
    m_ready = 1'b1;
  endtask

  // Drives one cycle of stimulus (called at posedge+1), scores it, and
  // consumes whatever prediction the DUT presents after the next edge.
  task automatic cycle(input logic pv, input logic [31:0] pc, input logic uv,
                       input logic [9:0] uidx, input logic ut, input logic um,
                       input logic [9:0] ughr);
    pred_t      e;
    pred_t      got;
    logic [9:0] idx;
    logic [1:0] c;
    logic       exp_ready;
    pred_valid_i = pv; pred_pc_i = pc; upd_valid_i = uv; upd_index_i = uidx;
    upd_taken_i = ut; upd_mispredict_i = um; upd_ghr_i = ughr;
    #1;
    exp_ready = m_ready && !(uv && um);
    n_tests++;
    if (pred_ready_o !== exp_ready) begin
      n_fail++;
      $display("FAIL pred_ready: got %b expected %b at %0t", pred_ready_o, exp_ready, $time);
    end
    c = 2'b00;
    if (pv && exp_ready) begin
      idx = pc[11:2] ^ m_ghr;
      c   = (uv && uidx == idx) ? sat(m_ctr[idx], ut) : m_ctr[idx];
      e.taken = c[1]; e.idx = idx; e.ghr = m_ghr;
      sb_q.push_back(e);
    end
    if (m_ready && uv) m_ctr[uidx] = sat(m_ctr[uidx], ut);
    if (m_ready && uv && um) m_ghr = {ughr[8:0], ut};
    else if (pv && exp_ready) m_ghr = {m_ghr[8:0], c[1]};
    @(posedge clk); #1;
    n_tests++;
    if (pred_valid_o !== (sb_q.size() != 0)) begin
      n_fail++;
      $display("FAIL pred_valid: got %b expected %b at %0t", pred_valid_o, sb_q.size() != 0, $time);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      got = {pred_taken_o, pred_index_o, pred_ghr_o};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL prediction: got taken=%b idx=%h ghr=%h expected taken=%b idx=%h ghr=%h",
                 got.taken, got.idx, got.ghr, e.taken, e.idx, e.ghr);
      end
    end
  endtask

  task automatic idle_inputs();
    pred_valid_i = 1'b0; pred_pc_i = '0; upd_valid_i = 1'b0; upd_index_i = '0;
    upd_taken_i = 1'b0; upd_mispredict_i = 1'b0; upd_ghr_i = '0;
  endtask

  // Counts edges until init_busy_o drops; flags any prediction output or
  // ready while busy. Leaves time at posedge+1.
  task automatic wait_init(output int n, output bit bad);
    n = 0; bad = 1'b0;
    while (n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (pred_valid_o !== 1'b0) bad = 1'b1;
      if (!init_busy_o) break;
      if (pred_ready_o !== 1'b0) bad = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests++;
    if ({pred_valid_o, pred_taken_o, pred_index_o, pred_ghr_o, init_busy_o, pred_ready_o} !== 25'b1_0) begin
      n_fail++;
      $display("FAIL %s: got valid=%b taken=%b idx=%h ghr=%h busy=%b ready=%b expected 0/0/000/000/1/0",
               tag, pred_valid_o, pred_taken_o, pred_index_o, pred_ghr_o, init_busy_o, pred_ready_o);
    end
  endtask

  task automatic test_reset();
    int n; bit bad;
    rstn = 1'b0;
    pred_valid_i = 1'b1; pred_pc_i = 32'h14;
    #3;
    check_reset_outputs("reset_state");
    // Updates during the sweep must be ignored, including a GHR recovery.
    upd_valid_i = 1'b1; upd_index_i = 10'd3; upd_taken_i = 1'b1;
    upd_mispredict_i = 1'b1; upd_ghr_i = 10'h3FF;
    @(negedge clk); rstn = 1'b1;
    model_reset();
    wait_init(n, bad);
    n_tests++;
    if (n != 1024 || bad) begin
      n_fail++;
      $display("FAIL init_sweep: got %0d busy edges (bad=%b) expected 1024 (bad=0)", n, bad);
    end
    model_init_done();
    cycle(1'b1, 32'h0, 1'b0, '0, 1'b0, 1'b0, '0);
    n_tests++;
    if (pred_taken_o !== 1'b0 || pred_ghr_o !== 10'h000) begin
      n_fail++;
      $display("FAIL first_pred: got taken=%b ghr=%h expected taken=0 ghr=000", pred_taken_o, pred_ghr_o);
    end
    cycle(1'b1, pc_for(10'd3), 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, '0, 1'b1, 10'd5, 1'b1, 1'b0, '0);
      cycle(1'b1, pc_for(10'd5), 1'b0, '0, 1'b0, 1'b0, '0);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1, 10'd5, 1'b0, 1'b0, '0);
      cycle(1'b1, pc_for(10'd5), 1'b0, '0, 1'b0, 1'b0, '0);
    end
    // Saturated at 00: one taken step must only reach 01 (still not-taken).
    cycle(1'b0, '0, 1'b1, 10'd5, 1'b1, 1'b0, '0);
    cycle(1'b1, pc_for(10'd5), 1'b0, '0, 1'b0, 1'b0, '0);
    n_tests++;
    if (pred_taken_o !== 1'b0 || pred_index_o !== 10'd5) begin
      n_fail++;
      $display("FAIL sat_floor: got taken=%b idx=%h expected taken=0 idx=005", pred_taken_o, pred_index_o);
    end
  endtask

  task automatic test_gshare_index();
    cycle(1'b1, 32'h14, 1'b1, 10'd50, 1'b1, 1'b1, 10'h001);
    cycle(1'b1, 32'h14, 1'b0, '0, 1'b0, 1'b0, '0);
    n_tests++;
    if (pred_index_o !== 10'h006 || pred_ghr_o !== 10'h003 || pred_taken_o !== 1'b0) begin
      n_fail++;
      $display("FAIL gshare_index: got idx=%h ghr=%h taken=%b expected idx=006 ghr=003 taken=0",
               pred_index_o, pred_ghr_o, pred_taken_o);
    end
    cycle(1'b1, 32'h0, 1'b0, '0, 1'b0, 1'b0, '0);
    n_tests++;
    if (pred_ghr_o !== 10'h006) begin
      n_fail++;
      $display("FAIL gshare_shift: got ghr=%h expected 006", pred_ghr_o);
    end
  endtask

  task automatic test_mispredict();
    cycle(1'b1, 32'h20, 1'b1, 10'd60, 1'b1, 1'b1, 10'h155);
    cycle(1'b1, 32'h0, 1'b0, '0, 1'b0, 1'b0, '0);
    n_tests++;
    if (pred_ghr_o !== 10'h2AB) begin
      n_fail++;
      $display("FAIL recovery_ghr: got %h expected 2ab", pred_ghr_o);
    end
  endtask

  task automatic test_bypass();
    cycle(1'b1, pc_for(10'd200), 1'b1, 10'd200, 1'b1, 1'b0, '0);
    n_tests++;
    if (pred_taken_o !== 1'b1 || pred_index_o !== 10'd200) begin
      n_fail++;
      $display("FAIL bypass: got taken=%b idx=%h expected taken=1 idx=0c8", pred_taken_o, pred_index_o);
    end
    cycle(1'b1, pc_for(10'd200), 1'b0, '0, 1'b0, 1'b0, '0);
    n_tests++;
    if (pred_taken_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_stored: got taken=%b expected 1", pred_taken_o);
    end
    cycle(1'b1, pc_for(10'd200), 1'b1, 10'd200, 1'b0, 1'b0, '0);
    n_tests++;
    if (pred_taken_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_dec: got taken=%b expected 0", pred_taken_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      logic       pv, uv, ut, um;
      logic [9:0] tgt, uidx, ughr;
      pv   = 1'($urandom_range(0, 3) != 0);
      uv   = 1'($urandom_range(0, 1));
      ut   = 1'($urandom_range(0, 1));
      um   = 1'($urandom_range(0, 7) == 0);
      tgt  = 10'($urandom_range(0, 15));
      uidx = 10'($urandom_range(0, 15));
      ughr = 10'($urandom_range(0, 1023));
      cycle(pv, pc_for(tgt), uv, uidx, ut, um, ughr);
    end
  endtask

  task automatic test_reset_in_flight();
    int n; bit bad;
    idle_inputs();
    pred_valid_i = 1'b1; pred_pc_i = 32'h40;
    @(posedge clk); #1;
    n_tests++;
    if (pred_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL inflight_valid: got %b expected 1", pred_valid_o);
    end
    rstn = 1'b0;
    #1;
    check_reset_outputs("reset_in_ready");
    model_reset();
    @(negedge clk); rstn = 1'b1;
    wait_init(n, bad);
    n_tests++;
    if (n != 1024 || bad) begin
      n_fail++;
      $display("FAIL reinit_ready: got %0d busy edges (bad=%b) expected 1024 (bad=0)", n, bad);
    end
    model_init_done();
    cycle(1'b1, 32'h0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_mid_init();
    int n; bit bad;
    idle_inputs();
    rstn = 1'b0;
    #2;
    model_reset();
    @(negedge clk); rstn = 1'b1;
    pred_valid_i = 1'b1;
    for (int i = 0; i < 300; i++) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_reset_outputs("reset_mid_init");
    @(negedge clk); rstn = 1'b1;
    wait_init(n, bad);
    n_tests++;
    if (n != 1024 || bad) begin
      n_fail++;
      $display("FAIL reinit_mid: got %0d busy edges (bad=%b) expected 1024 (bad=0)", n, bad);
    end
    model_init_done();
    cycle(1'b1, pc_for(10'd5), 1'b0, '0, 1'b0, 1'b0, '0);
    cycle(1'b1, pc_for(10'd200), 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within 2 ms");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_saturation();
    test_gshare_index();
    test_mispredict();
    test_bypass();
    test_back_to_back();
    test_reset_in_flight();
    test_reset_mid_init();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rip_sat_counter_predictor.md
RIP_SAT_COUNTER_PREDICTOR -- requirements
Module: rip_sat_counter_predictor

Interface
REQ-001 Parameter CTR_WIDTH, default 2: saturating counter width, range 1..4.
REQ-002 Parameter INDEX_WIDTH, default 10: table has 2^INDEX_WIDTH entries.
REQ-003 Parameter HISTORY_LEN, default 10: global history register (GHR) length, range 1..INDEX_WIDTH.
REQ-004 Parameter MODE, default 1: 0 = bimodal (GHR ignored), 1 = gshare.
REQ-005 Parameter PC_LSB, default 2: lowest PC bit used for indexing.
REQ-006 Parameter INIT_CTR, default 2^(CTR_WIDTH-1)-1: counter value written by the init sweep (weakly untaken).
REQ-007 clk  in  1  clock, rising edge.
REQ-008 rstn  in  1  reset, asynchronous, active-low.
REQ-009 pred_valid_i  in  1  prediction request.
REQ-010 pred_pc_i  in  32  branch PC.
REQ-011 pred_ready_o  out  1  request accepted this cycle.
REQ-012 pred_valid_o  out  1  prediction result valid.
REQ-013 pred_taken_o  out  1  predicted direction.
REQ-014 pred_index_o  out  INDEX_WIDTH  table index used; carried to the update.
REQ-015 pred_ghr_o  out  HISTORY_LEN  GHR value used for the index; carried to the update.
REQ-016 upd_valid_i  in  1  resolved-branch update.
REQ-017 upd_index_i  in  INDEX_WIDTH  index from the prediction.
REQ-018 upd_taken_i  in  1  actual direction.
REQ-019 upd_mispredict_i  in  1  the prediction was wrong; GHR recovery required.
REQ-020 upd_ghr_i  in  HISTORY_LEN  GHR snapshot from the prediction.
REQ-021 init_busy_o  out  1  init sweep in progress.

Function
REQ-022 FSM states: INIT, READY. Reset enters INIT; INIT moves to READY after the cycle that writes entry 2^INDEX_WIDTH-1.
REQ-023 INIT writes INIT_CTR to one entry per cycle, from index 0 ascending; sweep takes 2^INDEX_WIDTH cycles; init_busy_o = 1 throughout.
REQ-024 During INIT: pred_ready_o = 0; update inputs are ignored.
REQ-025 pred_ready_o = (state == READY) && !(upd_valid_i && upd_mispredict_i).
REQ-026 Index: bimodal = pred_pc_i[PC_LSB +: INDEX_WIDTH]; gshare = that value XOR the GHR zero-extended to INDEX_WIDTH.
REQ-027 Latency: one cycle; an accepted request at edge N gives pred_valid_o = 1 after edge N+1, for exactly one cycle; outputs are registered.
REQ-028 pred_taken_o = MSB of the counter read.
REQ-029 Update bypass: if an update writes the same index in the acceptance cycle, the prediction uses the post-update counter.
REQ-030 Counter update: upd_taken_i = 1 increments, saturating at 2^CTR_WIDTH-1; upd_taken_i = 0 decrements, saturating at 0.
REQ-031 Speculative GHR: on acceptance, GHR <= {GHR[HISTORY_LEN-2:0], predicted taken}; with HISTORY_LEN = 1, GHR <= predicted taken.
REQ-032 Recovery: upd_valid_i && upd_mispredict_i sets GHR <= {upd_ghr_i[HISTORY_LEN-2:0], upd_taken_i}; this has priority over any speculative shift.
REQ-033 Non-mispredicting updates leave the GHR unchanged.
REQ-034 MODE = 0: the GHR is still maintained; pred_ghr_o reports it; it does not affect the index.

Reset
REQ-035 Asynchronous assertion of rstn = 0 gives state = INIT, sweep pointer = 0, GHR = 0, pred_valid_o = 0, pred_taken_o = 0, pred_index_o = 0, pred_ghr_o = 0, init_busy_o = 1, pred_ready_o = 0.
REQ-036 Table contents are not reset asynchronously; the INIT sweep defines them.
REQ-037 Reset during READY or mid-INIT restarts the sweep from index 0; an in-flight prediction is discarded.

Structure
REQ-038 The predictor mode enum, the default parameter values, and a counter-value typedef parametrised by CTR_WIDTH belong in the shared branch-predictor package.
REQ-039 The counter table with one read port, one write port, the init write and the bypass forms sub-module rip_bp_counter_table.

Verification
REQ-040 Reset release, 2^INDEX_WIDTH = 1024 -> init_busy_o high 1024 cycles, then pred_ready_o = 1; the first prediction is not-taken (counter 01).
REQ-041 Bimodal, CTR_WIDTH = 2: 3 taken updates to index 5 -> counter = 11; 4 more -> still 11; 4 not-taken updates -> 00 and holds.
REQ-042 Gshare, GHR = 0b0000000011, PC = 0x14 -> pred_index_o = 0x005 ^ 0x003 = 0x006; after acceptance, GHR = 0b0000000110 if predicted not-taken.
REQ-043 Mispredict with upd_ghr_i = 0x155 and upd_taken_i = 1, together with pred_valid_i -> pred_ready_o = 0; next-cycle GHR = 0x2AB.
REQ-044 Same-cycle update (taken) and prediction to an index holding 01 -> pred_taken_o = 1; the stored counter becomes 10.
REQ-045 rstn asserted at sweep index 300 -> after release, the sweep restarts at 0 and takes 1024 cycles; pred_valid_o stays 0 throughout.
